// File: rtl/div_iter_param_if.sv
// Operand/result bundle for the iterative divider.
// No latency of its own: it only carries wires.
// The requester keeps start_i high until ready_o appears, then drops it to release the result.
interface div_iter_param_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;
  logic                 div_by_zero_o;

  // Requester side (pipeline / testbench)
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o, div_by_zero_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o, div_by_zero_o
  );
endinterface

// File: rtl/div_iter_param.sv
// Restoring radix-2 signed/unsigned divider. Result is {remainder, quotient}. Optional DIV_EARLY_OUT_EN skips leading-zero iterations.
// Latency: WIDTH+2 edges from accept to ready_o, or WIDTH-clz+2 with early-out; divide-by-zero takes 2 edges.
// Backpressure: the result and ready_o hold while start_i stays high. Dropping start_i frees the unit; annul_i aborts while iterating.
module div_iter_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  div_iter_param_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t               state;
  logic [2*WIDTH:0]     pr;        // partial remainder : quotient bits
  logic [WIDTH-1:0]     divisor;   // divisor magnitude
  logic [CNT_W-1:0]     cnt;
  logic                 sgn_q;
  logic                 sgn_r;
  logic                 dbz_flag;

  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic [WIDTH:0]       trial;
  logic [WIDTH+1:0]     diff;
  logic [2*WIDTH:0]     pr_next;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [CNT_W-1:0]     cnt_init;
  logic [WIDTH-1:0]     lo_init;

  // Two's-complement negation leaves the most-negative value as 2^(W-1), which is still correct when read as unsigned.
  assign mag1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Trial subtraction. The partial remainder plus the next dividend bit form W+1 bits.
  assign trial   = pr[2*WIDTH-1:WIDTH-1];
  assign diff    = {1'b0, trial} - {2'b00, divisor};
  assign pr_next = diff[WIDTH+1] ? {pr[2*WIDTH-1:0], 1'b0}
                                 : {diff[WIDTH:0], pr[WIDTH-2:0], 1'b1};

  // Signs were latched at accept, so the fix-up never looks at the live operands.
  assign quo_fix = sgn_q ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
  assign rem_fix = sgn_r ? -pr[2*WIDTH-1:WIDTH] : pr[2*WIDTH-1:WIDTH];

  assign bus.busy_o = (state != FREE);

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] clz;

  // Leading-zero count of |op1|. A zero magnitude counts as WIDTH, so no iterations are needed.
  always_comb begin
    clz = CNT_MAX;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag1[i]) clz = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign cnt_init = clz;
  assign lo_init  = mag1 << clz;
`else
  assign cnt_init = '0;
  assign lo_init  = mag1;
`endif

  // Control FSM and datapath. Reset/flush wins, then annul, then start.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state             <= FREE;
      pr                <= '0;
      divisor           <= '0;
      cnt               <= '0;
      sgn_q             <= 1'b0;
      sgn_r             <= 1'b0;
      dbz_flag          <= 1'b0;
      bus.result_o      <= '0;
      bus.ready_o       <= 1'b0;
      bus.div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          bus.ready_o       <= 1'b0;
          bus.result_o      <= '0;
          bus.div_by_zero_o <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            sgn_q    <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            sgn_r    <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            divisor  <= mag2;
            dbz_flag <= 1'b0;
            if (bus.opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              pr    <= {{(WIDTH+1){1'b0}}, lo_init};
              cnt   <= cnt_init;
              state <= ON;
            end
          end
        end
        BYZERO: begin
          pr       <= '0;
          dbz_flag <= 1'b1;
          state    <= END;
        end
        ON: begin
          if (bus.annul_i) begin
            state <= FREE;
          end else if (cnt != CNT_MAX) begin
            pr  <= pr_next;
            cnt <= cnt + 1'b1;
          end else begin
            pr    <= {1'b0, rem_fix, quo_fix};
            state <= END;
          end
        end
        END: begin
          bus.result_o      <= pr[2*WIDTH-1:0];
          bus.ready_o       <= 1'b1;
          bus.div_by_zero_o <= dbz_flag;
          if (!bus.start_i) begin
            state             <= FREE;
            bus.ready_o       <= 1'b0;
            bus.result_o      <= '0;
            bus.div_by_zero_o <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param, WIDTH=32. Expected results are queued when each operation is issued.
// A monitor pops and compares on every rising edge of ready_o.
// Reference: plain 64-bit integer division with truncation toward zero.
module tb_div_iter_param;
  localparam int W = 32;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  div_iter_param_if #(.WIDTH(W)) bus ();

  div_iter_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic longint ext(input bit sd, input logic [W-1:0] v);
    longint r;
    if (sd) r = {{32{v[W-1]}}, v};
    else    r = {32'b0, v};
    return r;
  endfunction

  // Reference: truncating division; the remainder takes the dividend's sign; MIN/-1 wraps.
  function automatic exp_t model(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, q, r;
    if (b == '0) begin
      e.res = '0;
      e.dbz = 1'b1;
    end else begin
      sa = ext(sd, a);
      sb = ext(sd, b);
      q  = sa / sb;
      r  = sa % sb;
      e.res = {r[W-1:0], q[W-1:0]};
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic int lat_of(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
    begin
      longint m;
      int     z;
      m = ext(sd, a);
      if (m < 0) m = -m;
      z = 0;
      if (m == 0) z = W;
      else while (m < (64'sd1 << (W - 1))) begin
        m = m * 2;
        z++;
      end
      return W - z + 2;
    end
`else
    return W + 2;
`endif
  endfunction

  function automatic exp_t mk(input logic [W-1:0] rem, input logic [W-1:0] quo, input logic dbz);
    exp_t e;
    e.res = {rem, quo};
    e.dbz = dbz;
    return e;
  endfunction

  task automatic drive(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  // Issue one operation, measure latency, then release it by dropping start_i or by flushing.
  task automatic run_op(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input int lat, input bit garbage,
                        input int hold, input bit flush_end);
    int k;
    bit busy_ok;
    @(posedge clk); #1;
    drive(sd, a, b);
    sb_q.push_back(e);
    @(posedge clk); #1;             // accepting edge has passed
    if (garbage) begin
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = ~sd;
    end
    k = 0;
    busy_ok = 1'b1;
    while (!bus.ready_o && k < W + 10) begin
      if (!bus.busy_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, lat);
    chk("busy_while_running", busy_ok, 1'b1);
    if (flush_end) begin
      flush = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_end_ready", bus.ready_o, 1'b0);
      chk("flush_end_result", bus.result_o, '0);
      chk("flush_end_busy", bus.busy_o, 1'b0);
      chk("flush_end_dbz", bus.div_by_zero_o, 1'b0);
    end else begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      if (hold > 0) begin
        chk("ready_hold", bus.ready_o, 1'b1);
        chk("result_hold", bus.result_o, e.res);
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      chk("release_ready", bus.ready_o, 1'b0);
      chk("release_result", bus.result_o, '0);
      chk("release_busy", bus.busy_o, 1'b0);
    end
  endtask

  // Monitor: every rising edge of ready_o is one completed result.
  task automatic monitor();
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready_o === 1'b1 && prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready result %h", bus.result_o);
        end else begin
          e = sb_q.pop_front();
          chk("result", bus.result_o, e.res);
          chk("div_by_zero", bus.div_by_zero_o, e.dbz);
        end
      end
      prev = bus.ready_o;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    bit           sd;
    rst = 1'b1;
    flush = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", bus.ready_o, 1'b0);
    chk("reset_result", bus.result_o, '0);
    chk("reset_busy", bus.busy_o, 1'b0);
    chk("reset_dbz", bus.div_by_zero_o, 1'b0);
    rst = 1'b0;

    // Directed cases with hand-derived results
    run_op(1'b0, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), lat_of(1'b0, 32'd100, 32'd7), 1'b0, 2, 1'b0);
    run_op(1'b1, -32'sd7, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), lat_of(1'b1, -32'sd7, 32'd2), 1'b1, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 1'b0), lat_of(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 1'b0, 1, 1'b0);
    run_op(1'b0, 32'd7, 32'd0, mk(32'd0, 32'd0, 1'b1), 2, 1'b0, 1, 1'b0);
    run_op(1'b0, 32'd5, 32'd3, mk(32'd2, 32'd1, 1'b0), lat_of(1'b0, 32'd5, 32'd3), 1'b0, 0, 1'b0);
    run_op(1'b0, 32'd0, 32'd5, mk(32'd0, 32'd0, 1'b0), lat_of(1'b0, 32'd0, 32'd5), 1'b0, 0, 1'b0);

    // Annul mid-operation (start still high): no result, then a clean new op
    @(posedge clk); #1;
    drive(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    chk("annul_busy", bus.busy_o, 1'b0);
    repeat (W + 4) @(posedge clk);
    #1;
    chk("annul_no_ready", bus.ready_o, 1'b0);
    run_op(1'b0, 32'd9, 32'd3, mk(32'd0, 32'd3, 1'b0), lat_of(1'b0, 32'd9, 32'd3), 1'b0, 0, 1'b0);

    // Flush during iteration
    @(posedge clk); #1;
    drive(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.start_i = 1'b0;
    chk("flush_on_busy", bus.busy_o, 1'b0);
    chk("flush_on_ready", bus.ready_o, 1'b0);
    chk("flush_on_result", bus.result_o, '0);
    repeat (W + 4) @(posedge clk);

    // Flush while holding a finished result
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, mk(32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0), lat_of(1'b1, 32'hFFFF_FF9C, 32'd7), 1'b0, 0, 1'b1);

    // Dropping start mid-operation still finishes, but the result is never presented
    @(posedge clk); #1;
    drive(1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (W + 6) @(posedge clk);
    #1;
    chk("start_drop_idle", bus.busy_o, 1'b0);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(sd, a, b, model(sd, a, b), lat_of(sd, a, b),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_iter_param.md
Name: div_iter_param

Overview:
- Parametrised multi-cycle restoring radix-2 integer divider; next-generation replacement for the fixed 32-bit execute-stage divider.
- Signed or unsigned division, selected per operation; returns packed {remainder, quotient}.
- Latches operand signs at acceptance, so operands need not be held after start.
- Adds busy and divide-by-zero status outputs, and optional leading-zero skip for reduced latency.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64. Derived localparam CNT_W = $clog2(WIDTH+1), the iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  pipeline flush; same effect as rst, synchronous.
- signed_div_i  in  1  1 = signed (two's complement), 0 = unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  level request; held high until ready_o is seen.
- annul_i  in  1  cancel the in-flight operation.
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- ready_o  out  1  result valid.
- busy_o  out  1  high in every state except FREE.
- div_by_zero_o  out  1  qualifies result_o when ready_o=1.

Behaviour:
- Reset/flush (rst|flush at a clk edge):
  - state=FREE; ready_o=0; result_o=0; div_by_zero_o=0; busy_o=0.
  - Takes priority over all other inputs in any state, including mid-operation.
- States: FREE, BYZERO, ON, END.
- FREE:
  - Accept when start_i=1 and annul_i=0.
  - On accept, latch the following:
    - sgn_q = signed_div_i & (op1[W-1]^op2[W-1]).
    - sgn_r = signed_div_i & op1[W-1].
    - Magnitudes |op1| and |op2|. Signed magnitude uses two's negate; most-negative stays 2^(W-1), which is correct as unsigned.
  - Divisor==0 → BYZERO; otherwise → ON with the partial-remainder register {W+1 zero, |op1|} and cnt=0.
  - While idle: ready_o=0, result_o=0.
- BYZERO: next state END, result forced 0, div_by_zero flag set.
- ON:
  - annul_i=1 → FREE, no result.
  - Else, if cnt!=WIDTH: perform one iteration.
    - diff = {1'b0, rem_hi} - {1'b0, divisor}.
    - Borrow → shift left, inserting 0.
    - Else → rem_hi=diff[W-1:0], then shift and insert 1.
    - cnt++.
  - cnt==WIDTH: apply sign fix-up using the latched signs only.
    - Negate quotient if sgn_q.
    - Negate remainder if sgn_r.
    - Then go to END.
- END:
  - Register result_o, ready_o=1, div_by_zero_o=flag.
  - Outputs hold while start_i=1.
  - start_i=0 → FREE, clearing ready_o/result_o/div_by_zero_o in the same edge.
  - annul_i ignored in END and BYZERO.
- Latency, from the accepting edge to ready_o high:
  - WIDTH+2 edges for a normal operation.
  - 2 edges for divide-by-zero.
- Arithmetic rules:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN/-1 → quotient=MIN (wraps), remainder=0; no overflow flag.
  - Divide-by-zero → result_o=0, div_by_zero_o=1.
- Simultaneous events:
  - rst/flush beats annul_i, which beats start_i.
  - start_i dropping in ON does not abort; the result is still produced, and END then returns to FREE on the next edge.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined:
  - FREE computes clz = leading zeros of |op1| (0..WIDTH-1; |op1|=0 treated as clz=WIDTH).
  - Loads the low half with |op1|<<clz (0 when |op1|=0) and sets cnt=clz, skipping leading-zero iterations.
  - Normal latency becomes WIDTH-clz+2 edges; results are bit-identical to the non-feature build.
- Undefined: fixed WIDTH+2 latency; no clz logic is synthesised.

Test Plan:
- W=32, unsigned 100/7 → result_o={32'd2, 32'd14}, ready_o at edge 34, busy_o high edges 1-34.
- Signed -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Operands changed to garbage after the accept edge → same result.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 7/0 → result_o=0, div_by_zero_o=1, ready_o at edge 2.
- Start 100/7, annul_i pulse at edge 10 → FREE, ready_o never rises. New start 9/3 → {0, 3} after WIDTH+2 edges.
- flush during ON (edge 5), and separately during END → all outputs 0 next edge. Holding start_i in END keeps ready_o=1; dropping it clears ready_o the next edge.
- DIV_EARLY_OUT_EN defined, W=32, 5/3 → clz=29, ready_o at edge 5, result {2, 1}.
- DIV_EARLY_OUT_EN defined, 0/5 → ready_o at edge 2, result 0. Randomised compare against the non-feature build.
